// File: rtl/fft_seq_pkg.sv
// Shared state encoding and defaults for the FFT frame sequencer.
package fft_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        SAMPLE   = 3'd2,
        WAIT_FFT = 3'd3,
        SEND     = 3'd4,
        SPI_WAIT = 3'd5,
        HOLD     = 3'd6
    } seq_state_e;

    localparam int DEF_PERIOD_C = 16000;
    localparam int TIMEOUT_C    = 65535;

    function automatic logic is_busy_state(input seq_state_e s);
        return (s == ARM) || (s == SAMPLE) || (s == WAIT_FFT) ||
               (s == SEND) || (s == SPI_WAIT);
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_timer.sv
// Free-running frame period counter; the period is latched while the sequencer arms.
module seq_period_timer #(
    parameter int PERIOD_W   = 24,
    parameter int DEF_PERIOD = 16000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] eff_period;

    // A zero period selects the default; a period of one cannot be honoured, so it runs at two.
    always_comb begin
        if (period_q == '0) begin
            eff_period = PERIOD_W'(DEF_PERIOD);
        end else if (period_q == PERIOD_W'(1)) begin
            eff_period = PERIOD_W'(2);
        end else begin
            eff_period = period_q;
        end
    end

    assign tick_o = (cnt_q == eff_period - PERIOD_W'(1));

    always_comb begin
        period_d = load_i ? period_i : period_q;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Periodic frame scheduler: sampler start, fft wait, SPI output, with overrun
// counting and a per-state watchdog that aborts hung stages.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int PERIOD_W   = 24,
    parameter int DEF_PERIOD = DEF_PERIOD_C,
    parameter int TIMEOUT    = TIMEOUT_C,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                sample_run,
    input  logic                fft_finish,
    input  logic                spi_busy,
    input  logic                err_clr,
    output logic                sample_start,
    output logic                spi_start,
    output logic                frame_done,
    output logic                busy,
    output logic                error,
    output logic [CNT_W-1:0]    frame_count,
    output logic [CNT_W-1:0]    overrun_count
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    seq_state_e       state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             seen_q, seen_d;
    logic             fft_done_q, fft_done_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic [CNT_W-1:0] overrun_q, overrun_d;
    logic             sample_start_q, spi_start_q, frame_done_q, busy_q;

    logic tick;
    logic abort;
    logic frame_evt;
    logic fft_seen;
    logic wd_expired;
    logic wd_active;
    logic state_change;

    seq_period_timer #(
        .PERIOD_W   (PERIOD_W),
        .DEF_PERIOD (DEF_PERIOD)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (state_change && (state_d == ARM)),
        .load_i   (state_q == ARM),
        .period_i (period_in),
        .tick_o   (tick)
    );

    assign wd_active    = (state_q == SAMPLE) || (state_q == WAIT_FFT) || (state_q == SPI_WAIT);
    assign wd_expired   = wd_active && (wd_q == WD_W'(TIMEOUT - 1));
    assign fft_seen     = fft_done_q || fft_finish;
    assign state_change = (state_d != state_q);

    // seen_q remembers that the stage input has risen, so a low level afterwards is its fall.
    always_comb begin
        state_d   = state_q;
        abort     = 1'b0;
        frame_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = ARM;
            end
            ARM: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                if (seen_q && !sample_run) begin
                    state_d = fft_seen ? SEND : WAIT_FFT;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            WAIT_FFT: begin
                if (fft_seen) begin
                    state_d = SEND;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            SEND: begin
                state_d = SPI_WAIT;
            end
            SPI_WAIT: begin
                if (seen_q && !spi_busy) begin
                    frame_evt = 1'b1;
                    state_d   = enable ? HOLD : IDLE;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end
            HOLD: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    state_d = ARM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        wd_d          = '0;
        seen_d        = seen_q;
        fft_done_d    = fft_done_q;
        error_d       = error_q;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;

        if (wd_active && !state_change) wd_d = wd_q + WD_W'(1);

        if (state_change) begin
            seen_d = 1'b0;
        end else if ((state_q == SAMPLE && sample_run) || (state_q == SPI_WAIT && spi_busy)) begin
            seen_d = 1'b1;
        end

        // Clearing on SEND/ARM entry wins over a finish pulse arriving in the same cycle.
        if (abort || (state_change && (state_d == SEND || state_d == ARM))) begin
            fft_done_d = 1'b0;
        end else if (fft_finish && (state_q == ARM || state_q == SAMPLE || state_q == WAIT_FFT)) begin
            fft_done_d = 1'b1;
        end

        if (abort) begin
            error_d = 1'b1;
        end else if (err_clr) begin
            error_d = 1'b0;
        end

        if (frame_evt) frame_count_d = frame_count_q + CNT_W'(1);

        if (tick && is_busy_state(state_q) && (overrun_q != {CNT_W{1'b1}})) begin
            overrun_d = overrun_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            wd_q           <= '0;
            seen_q         <= 1'b0;
            fft_done_q     <= 1'b0;
            error_q        <= 1'b0;
            frame_count_q  <= '0;
            overrun_q      <= '0;
            sample_start_q <= 1'b0;
            spi_start_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wd_q           <= wd_d;
            seen_q         <= seen_d;
            fft_done_q     <= fft_done_d;
            error_q        <= error_d;
            frame_count_q  <= frame_count_d;
            overrun_q      <= overrun_d;
            sample_start_q <= (state_d == ARM);
            spi_start_q    <= (state_d == SEND);
            frame_done_q   <= frame_evt;
            busy_q         <= is_busy_state(state_d);
        end
    end

    assign sample_start  = sample_start_q;
    assign spi_start     = spi_start_q;
    assign frame_done    = frame_done_q;
    assign busy          = busy_q;
    assign error         = error_q;
    assign frame_count   = frame_count_q;
    assign overrun_count = overrun_q;

endmodule
